// File: rtl/lmg_move_packer.sv
// lmg_move_packer: packs valid moves from LMG FIFO words contiguously into the move-list RAM.
//
// Purpose
//   On a start rising edge the packer pulses lmgReset-equivalent output lmg_reset, waits for the
//   LMG to report done, then pops FIFO words one at a time. Every slot of every word is scanned;
//   valid moves are written to BASE_ADDR+1 onwards. When a word with no valid slot is seen, the
//   move count is written to BASE_ADDR, a zero terminator follows the last move, and done rises.
//   Moves beyond MAX_MOVES are dropped and flagged with the sticky overflow output.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous active-low reset; aborts any run immediately
//   start      in   level start; a rising edge while idle begins a run
//   lmg_reset  out  one-cycle pulse to the LMG when a run begins
//   lmg_done   in   LMG finished, FIFO holds results
//   lmg_rden   out  one-cycle FIFO pop
//   lmg_fifo   in   SLOTS x (invalid flag, MOVE_W-bit move); valid the cycle after lmg_rden
//   ram_wren   out  RAM write enable
//   ram_addr   out  RAM write address (meaningful only with ram_wren)
//   ram_data   out  RAM write data (meaningful only with ram_wren)
//   busy       out  run in progress (WAIT through TERM)
//   done       out  move list complete
//   move_count out  moves written in this run
//   overflow   out  valid moves were dropped because capacity was reached
module lmg_move_packer #(
    parameter int SLOTS      = 8,
    parameter int MOVE_W     = 18,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15,
    parameter int BASE_ADDR  = 16,
    parameter int MAX_MOVES  = 255,
    localparam int CW = $clog2(MAX_MOVES + 1),
    localparam int WW = SLOTS * (MOVE_W + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  lmg_reset,
    input  logic                  lmg_done,
    output logic                  lmg_rden,
    input  logic [WW-1:0]         lmg_fifo,
    output logic                  ram_wren,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    output logic                  busy,
    output logic                  done,
    output logic [CW-1:0]         move_count,
    output logic                  overflow
);
    localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;

    typedef enum logic [2:0] {IDLE, WAIT, POP, LATCH, SCAN, HDR, TERM, DONE} stateType;

    stateType        state, nextState;
    logic            startQ;
    logic            lmgResetQ;
    logic [WW-1:0]   wordQ;
    logic [SW-1:0]   slotIdx;
    logic [CW-1:0]   count;
    logic            ovf;
    logic            anyValid;
    logic            startEdge;
    logic [MOVE_W:0] curSlot;
    logic            slotValid;
    logic            full;
    logic            lastSlot;
    logic [ADDR_WIDTH-1:0] moveAddr;

    assign startEdge = start & ~startQ;
    assign curSlot   = wordQ[int'(slotIdx) * (MOVE_W + 1) +: MOVE_W + 1];
    assign slotValid = ~curSlot[MOVE_W];
    assign full      = count == CW'(MAX_MOVES);
    assign lastSlot  = slotIdx == SW'(SLOTS - 1);
    // Next free move slot; also where the terminator lands once scanning is over.
    assign moveAddr  = ADDR_WIDTH'(BASE_ADDR + 1) + ADDR_WIDTH'(count);

    always_ff @(posedge clk) begin
        // Edge history tracks start even in reset, so a start held through reset cannot
        // masquerade as a fresh rising edge afterwards.
        startQ <= start;
        if (!reset) begin
            state     <= IDLE;
            lmgResetQ <= 1'b0;
            wordQ     <= '0;
            slotIdx   <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            anyValid  <= 1'b0;
        end else begin
            state     <= nextState;
            lmgResetQ <= (state == IDLE) && startEdge;
            if (state == IDLE && startEdge) begin
                count <= '0;
                ovf   <= 1'b0;
            end
            if (state == LATCH) begin
                wordQ    <= lmg_fifo;
                slotIdx  <= '0;
                anyValid <= 1'b0;
            end
            if (state == SCAN) begin
                slotIdx  <= lastSlot ? '0 : slotIdx + SW'(1);
                anyValid <= anyValid | slotValid;
                if (slotValid && !full)
                    count <= count + CW'(1);
                if (slotValid && full)
                    ovf <= 1'b1;
            end
        end
    end

    always_comb begin
        nextState = state;
        lmg_rden  = 1'b0;
        ram_wren  = 1'b0;
        ram_addr  = '0;
        ram_data  = '0;
        case (state)
            IDLE:  nextState = startEdge ? WAIT : IDLE;
            WAIT:  nextState = lmg_done ? POP : WAIT;
            POP: begin
                lmg_rden  = 1'b1;
                nextState = LATCH;
            end
            LATCH: nextState = SCAN;
            SCAN: begin
                ram_wren = slotValid & ~full;
                ram_addr = moveAddr;
                ram_data = DATA_WIDTH'(curSlot[MOVE_W-1:0]);
                // An all-invalid word marks the end of the LMG output.
                if (lastSlot)
                    nextState = (anyValid | slotValid) ? POP : HDR;
            end
            HDR: begin
                ram_wren  = 1'b1;
                ram_addr  = ADDR_WIDTH'(BASE_ADDR);
                ram_data  = DATA_WIDTH'(count);
                nextState = TERM;
            end
            TERM: begin
                ram_wren  = 1'b1;
                ram_addr  = moveAddr;
                nextState = DONE;
            end
            DONE:  nextState = start ? DONE : IDLE;
        endcase
    end

    assign lmg_reset  = lmgResetQ;
    assign busy       = (state != IDLE) && (state != DONE);
    assign done       = state == DONE;
    assign move_count = count;
    assign overflow   = ovf;
endmodule
